mc_control_fsm: RTL
===================

# mc_control_fsm

Parametrised multicycle RV32I control unit, successor to the fixed control FSM of the current multicycle core. It sequences fetch, decode, execute, memory and writeback for lw, sw, R-type, I-type ALU, the full conditional branch set, and jal. It adds a memory ready handshake, decode-time illegal-instruction detection with a sticky halt, and a retired-instruction counter. It sits between the instruction register, ALU flags and memory, and drives every datapath mux and enable in the core top.

## Interface
- MEM_HANDSHAKE, 1: 1 = memory states wait on i_mem_ready; 0 = memory treated as always ready.
- EXT_BRANCH, 1: 1 = beq/bne/blt/bge/bltu/bgeu; 0 = beq only.
- CNT_W, 32: retired-counter width.
- i_clk  in  1  clock, rising edge.
- i_rstn  in  1  asynchronous active-low reset.
- i_instr  in  32  instruction register output.
- i_zero, i_lt, i_ltu  in  1 each  ALU flags: equal, signed less-than, unsigned less-than.
- i_mem_ready  in  1  memory access complete this cycle.
- o_PCWrite, o_IRWrite, o_RegWrite, o_MemWrite, o_AdSrc  out  1 each  datapath enables and address select.
- o_ResultSrc, o_ALUSrcA, o_ALUSrcB, o_ImmSrc  out  2 each  mux selects.
- o_ALUControl  out  3  ALU operation.
- o_illegal  out  1  sticky illegal-instruction flag.
- o_retired  out  CNT_W  count of completed instructions.
- o_state  out  4  current state, for debug.

## Operation
- Encodings:
  - ALUSrcA: 00 PC, 01 OldPC, 10 A.
  - ALUSrcB: 00 B, 01 ImmExt, 10 constant 4.
  - ResultSrc: 00 ALUOut, 01 Data, 10 ALUResult.
  - ImmSrc: 00 I, 01 S, 10 B, 11 J.
  - ALUControl: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt.
- Outputs are combinational from the state, plus i_instr; o_PCWrite also depends on the flags. Any select not listed for a state is 00, and any enable not listed is 0.
- FETCH:
  - AdSrc=0, A=00, B=10, add, ResultSrc=10; IRWrite=PCWrite=rdy.
  - Stay in FETCH while !rdy, else go to DECODE.
  - rdy is i_mem_ready, or 1 when MEM_HANDSHAKE=0.
- DECODE: A=01, B=01, add. ImmSrc=11 if opcode is 1101111, else 10. Next state by opcode:
  - 0000011 or 0100011 → MEMADR.
  - 0110011 → EXECUTER.
  - 0010011 → EXECUTEI.
  - 1100011 → BRANCH.
  - 1101111 → JAL.
  - Anything else → HALT.
- Also illegal, and therefore → HALT:
  - R-type or I-type funct3 in {001, 011, 101}.
  - Branch funct3 in {010, 011}.
  - Any branch funct3 ≠ 000 when EXT_BRANCH=0.
- MEMADR: A=10, B=01, add, ImmSrc=00 for lw and 01 for sw. Next state is MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: AdSrc=1. Stay while !rdy, else go to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1. Next state FETCH.
- MEMWRITE: AdSrc=1, MemWrite=1, held until rdy. Next state FETCH.
- EXECUTER: A=10, B=00, ALU by funct decode. Next state ALUWB.
- EXECUTEI: A=10, B=01, ImmSrc=00, ALU by funct decode. Next state ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1. Next state FETCH.
- BRANCH: A=10, B=00, sub, ResultSrc=00, PCWrite=taken. Next state FETCH. Taken condition by funct3:
  - 000: i_zero.
  - 001: !i_zero.
  - 100: i_lt.
  - 101: !i_lt.
  - 110: i_ltu.
  - 111: !i_ltu.
- JAL: A=01, B=10, add, ResultSrc=00, PCWrite=1. Next state ALUWB.
- HALT:
  - Every enable is 0 and o_illegal=1. HALT is left only by reset.
  - o_illegal is registered: it is set on the DECODE→HALT edge.
- Funct decode:
  - funct3 000: add; sub for R-type with funct7[5]=1.
  - 010 → slt; 100 → xor; 110 → or; 111 → and.
- o_retired:
  - Increments by 1 on every transition into FETCH from MEMWB, MEMWRITE, ALUWB or BRANCH.
  - A branch counts whether or not it is taken.
  - Wraps modulo 2^CNT_W.

## Timing
- Reset:
  - While i_rstn=0, state is FETCH, o_retired=0, o_illegal=0, and all enables are forced to 0.
  - Release takes effect on the first rising edge with i_rstn=1.
- Reset asserted mid-operation (including inside HALT or during a memory wait) returns to FETCH immediately, with no write enable asserted.
- Latency with MEM_HANDSHAKE=0:
  - lw 5 cycles; sw, R-type, I-type and jal 4 cycles; branch 3 cycles.
  - Each wait cycle adds 1.
- i_mem_ready is sampled only in FETCH, MEMREAD and MEMWRITE; it is ignored in every other state.
- MemWrite and AdSrc stay stable for the whole MEMWRITE wait.
- The flags are sampled in the BRANCH cycle only.

## Test plan
- **Reset:** hold reset, then release → state=0 (FETCH), o_retired=0, IRWrite=PCWrite=1 on the first cycle.
- **lw:** lw with i_mem_ready low for 2 cycles in MEMREAD → 7 cycles total, RegWrite asserted only in MEMWB with ResultSrc=01, o_retired=1.
- **Branches:**
  - bne with i_zero=1 → PCWrite=0.
  - blt with i_lt=1 → PCWrite=1.
  - With EXT_BRANCH=0, bne (funct3=001) → HALT with o_illegal=1.
- **Illegal opcode and reset recovery:** opcode 0000000 → HALT, o_illegal=1, no enables for 10 cycles; a reset pulse then clears o_illegal and returns to FETCH.
- **R-type decode and writeback:** add, sub (funct7=0100000), slt, xor, or, and → ALUControl 000, 001, 101, 100, 011, 010; writeback in ALUWB.
- **Counter wrap:** with CNT_W=4, 17 R-type instructions → o_retired=1.

Source files
------------

// File: rtl/mc_control_fsm.sv
// Multicycle RV32I control unit: sequences fetch/decode/execute/memory/writeback,
// with a memory ready handshake, sticky illegal-instruction halt and retired counter.
module mc_control_fsm #(
  parameter bit          MEM_HANDSHAKE = 1'b1,
  parameter bit          EXT_BRANCH    = 1'b1,
  parameter int unsigned CNT_W         = 32,
  localparam int unsigned XLEN         = 32,
  localparam int unsigned ST_W         = 4
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic [XLEN-1:0]  i_instr,
  input  logic             i_zero,
  input  logic             i_lt,
  input  logic             i_ltu,
  input  logic             i_mem_ready,
  output logic             o_PCWrite,
  output logic             o_IRWrite,
  output logic             o_RegWrite,
  output logic             o_MemWrite,
  output logic             o_AdSrc,
  output logic [1:0]       o_ResultSrc,
  output logic [1:0]       o_ALUSrcA,
  output logic [1:0]       o_ALUSrcB,
  output logic [1:0]       o_ImmSrc,
  output logic [2:0]       o_ALUControl,
  output logic             o_illegal,
  output logic [CNT_W-1:0] o_retired,
  output logic [ST_W-1:0]  o_state
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_REG   = 2'b10;
  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;
  localparam logic [1:0] IMM_I      = 2'b00;
  localparam logic [1:0] IMM_S      = 2'b01;
  localparam logic [1:0] IMM_B      = 2'b10;
  localparam logic [1:0] IMM_J      = 2'b11;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef enum logic [ST_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_HALT     = 4'd11
  } state_e;

  state_e           state_q, state_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       rdy;
  logic       alu_f3_bad;
  logic       br_f3_bad;
  state_e     decode_next;
  logic [2:0] alu_op;
  logic       taken;
  logic       retire;

  logic       pc_write, ir_write, reg_write, mem_write, ad_src;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_ctrl;

  assign opcode   = i_instr[6:0];
  assign funct3   = i_instr[14:12];
  assign funct7b5 = i_instr[30];

  // Remaining instruction fields belong to the datapath, not to control.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{i_instr[31], i_instr[29:15], i_instr[11:7]};

  assign rdy = MEM_HANDSHAKE ? i_mem_ready : 1'b1;

  assign alu_f3_bad = (funct3 == 3'b001) || (funct3 == 3'b011) || (funct3 == 3'b101);
  assign br_f3_bad  = (funct3 == 3'b010) || (funct3 == 3'b011) ||
                      (!EXT_BRANCH && (funct3 != 3'b000));

  // Decode-time dispatch; anything unsupported parks the core in HALT.
  always_comb begin
    decode_next = S_HALT;
    case (opcode)
      OP_LOAD, OP_STORE: decode_next = S_MEMADR;
      OP_RTYPE:          if (!alu_f3_bad) decode_next = S_EXECUTER;
      OP_ITYPE:          if (!alu_f3_bad) decode_next = S_EXECUTEI;
      OP_BRANCH:         if (!br_f3_bad)  decode_next = S_BRANCH;
      OP_JAL:            decode_next = S_JAL;
      default:           decode_next = S_HALT;
    endcase
  end

  // ALU operation from funct3; sub only for R-type with funct7[5].
  always_comb begin
    alu_op = ALU_ADD;
    case (funct3)
      3'b000:  if ((opcode == OP_RTYPE) && funct7b5) alu_op = ALU_SUB;
      3'b010:  alu_op = ALU_SLT;
      3'b100:  alu_op = ALU_XOR;
      3'b110:  alu_op = ALU_OR;
      3'b111:  alu_op = ALU_AND;
      default: alu_op = ALU_ADD;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:  taken = i_zero;
      3'b001:  taken = !i_zero;
      3'b100:  taken = i_lt;
      3'b101:  taken = !i_lt;
      3'b110:  taken = i_ltu;
      3'b111:  taken = !i_ltu;
      default: taken = 1'b0;
    endcase
  end

  // Next-state and control outputs.
  always_comb begin
    state_d    = state_q;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    ad_src     = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_REG;
    imm_src    = IMM_I;
    alu_ctrl   = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURES;
        ir_write   = rdy;
        pc_write   = rdy;
        if (rdy) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        imm_src   = (opcode == OP_JAL) ? IMM_J : IMM_B;
        state_d   = decode_next;
      end
      S_MEMADR: begin
        alu_src_a = SRCA_REG;
        alu_src_b = SRCB_IMM;
        imm_src   = (opcode == OP_STORE) ? IMM_S : IMM_I;
        state_d   = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        ad_src = 1'b1;
        if (rdy) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        ad_src    = 1'b1;
        mem_write = 1'b1;
        if (rdy) state_d = S_FETCH;
      end
      S_EXECUTER: begin
        alu_src_a = SRCA_REG;
        alu_src_b = SRCB_REG;
        alu_ctrl  = alu_op;
        state_d   = S_ALUWB;
      end
      S_EXECUTEI: begin
        alu_src_a = SRCA_REG;
        alu_src_b = SRCB_IMM;
        imm_src   = IMM_I;
        alu_ctrl  = alu_op;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        result_src = RES_ALUOUT;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = SRCA_REG;
        alu_src_b  = SRCB_REG;
        alu_ctrl   = ALU_SUB;
        result_src = RES_ALUOUT;
        pc_write   = taken;
        state_d    = S_FETCH;
      end
      S_JAL: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALUOUT;
        pc_write   = 1'b1;
        state_d    = S_ALUWB;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // An instruction retires when its last state hands back to FETCH.
  always_comb begin
    retire = (state_d == S_FETCH) &&
             ((state_q == S_MEMWB) || (state_q == S_MEMWRITE) ||
              (state_q == S_ALUWB) || (state_q == S_BRANCH));
    retired_d = retire ? (retired_q + CNT_W'(1)) : retired_q;
    illegal_d = illegal_q || ((state_q == S_DECODE) && (state_d == S_HALT));
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      retired_q <= retired_d;
    end
  end

  // Enables are held low for the whole time reset is asserted.
  assign o_PCWrite    = pc_write  & i_rstn;
  assign o_IRWrite    = ir_write  & i_rstn;
  assign o_RegWrite   = reg_write & i_rstn;
  assign o_MemWrite   = mem_write & i_rstn;
  assign o_AdSrc      = ad_src    & i_rstn;
  assign o_ResultSrc  = result_src;
  assign o_ALUSrcA    = alu_src_a;
  assign o_ALUSrcB    = alu_src_b;
  assign o_ImmSrc     = imm_src;
  assign o_ALUControl = alu_ctrl;
  assign o_illegal    = illegal_q;
  assign o_retired    = retired_q;
  assign o_state      = state_q;

endmodule
